ip_param_nbuf: RTL and testbench
================================

IP_PARAM_NBUF -- requirements
Module: ip_param_nbuf

Interface
REQ-001 SHALL have parameter FW, default 16, meaning the parameter word width in bits.
REQ-002 SHALL have parameter DW, default 512, meaning the input package width in bits; DW SHALL be a multiple of FW.
REQ-003 SHALL have parameter WL, default 288, meaning the words per bank; WL SHALL be a multiple of PL = DW/FW.
REQ-004 SHALL have parameter NB, default 2, meaning the bank count (NB >= 2); PN = WL/PL packages per bank, BW = clog2(NB), AW = clog2(WL).
REQ-005 clk_i  input  1  single clock, all logic on the rising edge.
REQ-006 rstn_i  input  1  reset, asynchronous, active-low.
REQ-007 wr_valid_i  input  1  param_i holds a valid package.
REQ-008 param_i  input  DW  package; word j = param_i[(j+1)*FW-1 : j*FW].
REQ-009 wr_ready_o  output  1  the current write bank can accept a package.
REQ-010 wr_bank_o  output  BW  index of the current write bank.
REQ-011 wr_done_o  output  1  one-cycle pulse when a bank becomes full.
REQ-012 full_o  output  NB  per-bank full flags.
REQ-013 rd_req_i  input  1  consumer requests the next full bank.
REQ-014 rd_busy_o  output  1  a bank is held for reading.
REQ-015 rd_bank_o  output  BW  index of the current read bank.
REQ-016 rd_addr_i  input  AW  word address within the read bank.
REQ-017 rd_release_i  input  1  consumer is finished with the held bank.
REQ-018 ip_param_o  output  FW  registered read data.
REQ-019 ip_param_vld_o  output  1  ip_param_o is valid.

Function
REQ-020 Write accept SHALL occur only when wr_valid_i=1 and wr_ready_o=1; wr_ready_o SHALL be combinational ~full_o[wr_bank_o].
REQ-021 On accept, word j SHALL be stored at bank[wr_bank_o][pkt_cnt*PL+j] (direct addressing, no shifting); pkt_cnt SHALL then increment.
REQ-022 On the accept where pkt_cnt=PN-1: pkt_cnt<=0; full_o[wr_bank_o]<=1; wr_done_o=1 the next cycle only; wr_bank_o SHALL advance modulo NB (NB-1 wraps to 0).
REQ-023 When the next write bank is already full, wr_ready_o SHALL stay 0 until that bank is released; packages offered meanwhile SHALL be ignored, with no storage and no count change.
REQ-024 When rd_req_i=1, rd_busy_o=0 and full_o[rd_bank_o]=1, rd_busy_o SHALL be 1 from the next cycle; otherwise rd_req_i SHALL be ignored.
REQ-025 While rd_busy_o=1: ip_param_o <= bank[rd_bank_o][rd_addr_i] and ip_param_vld_o <= 1, giving 1-cycle latency; rd_addr_i >= WL SHALL give 0 with vld=1.
REQ-026 While rd_busy_o=0: ip_param_o SHALL hold its last value and ip_param_vld_o SHALL be 0.
REQ-027 When rd_release_i=1 and rd_busy_o=1: full_o[rd_bank_o]<=0, rd_busy_o<=0, rd_bank_o advances modulo NB; rd_release_i with rd_busy_o=0 SHALL be ignored.
REQ-028 A release and a bank completion in the same cycle SHALL both take effect, since they always target different banks.
REQ-029 When a release frees the bank the writer waits on, wr_ready_o SHALL be 1 the following cycle.
REQ-030 rd_req_i and rd_release_i asserted in the same cycle with rd_busy_o=0 SHALL perform the request only.

Reset
REQ-031 rstn_i=0 SHALL immediately clear pkt_cnt, wr_bank_o, rd_bank_o, full_o, rd_busy_o, wr_done_o, ip_param_vld_o and ip_param_o to 0, including in the middle of a fill or a read; bank storage contents SHALL NOT be reset.
REQ-032 After reset, the first accepted package SHALL go to bank 0, words 0..PL-1.

Verification (FW=16, DW=512, WL=288, NB=2: PL=32, PN=9)
REQ-033 Send 9 packages, word value = global index -> full_o=2'b01 and a single wr_done_o pulse; rd_req, then rd_addr=0..287 -> ip_param_o = address, 1 cycle later.
REQ-034 Fill banks 0 and 1 (18 packages) -> full_o=2'b11 and wr_ready_o=0; a 19th package held valid for 5 cycles is not stored; release bank 0 -> wr_ready_o=1 the next cycle and the package lands in bank 0 word 0..31.
REQ-035 Release bank 0 on the same cycle as the 9th accept into bank 1 -> full_o=2'b10, rd_bank_o=1, wr_bank_o=0.
REQ-036 rd_req_i with full_o=0 -> rd_busy_o stays 0 and ip_param_vld_o=0; rd_addr_i=300 while busy -> ip_param_o=0.
REQ-037 Reset after 4 packages -> all outputs 0; the next 9 packages complete bank 0 with the wr_done_o pulse on the 9th.
REQ-038 NB=3, 27 packages -> wr_bank_o sequence 0,1,2 and full_o=3'b111; releases advance rd_bank_o 0,1,2,0.

Source files
------------

// File: rtl/ip_param_nbuf.sv
// N-bank parameter buffer: a producer fills banks package-by-package while a
// consumer holds full banks for random word reads, both rotating round-robin.
module ip_param_nbuf #(
    parameter  int FW = 16,
    parameter  int DW = 512,
    parameter  int WL = 288,
    parameter  int NB = 2,
    localparam int PL = DW / FW,
    localparam int PN = WL / PL,
    localparam int BW = $clog2(NB),
    localparam int AW = $clog2(WL)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          wr_valid_i,
    input  logic [DW-1:0] param_i,
    output logic          wr_ready_o,
    output logic [BW-1:0] wr_bank_o,
    output logic          wr_done_o,
    output logic [NB-1:0] full_o,
    input  logic          rd_req_i,
    output logic          rd_busy_o,
    output logic [BW-1:0] rd_bank_o,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_release_i,
    output logic [FW-1:0] ip_param_o,
    output logic          ip_param_vld_o
);

    localparam int CW = (PN > 1) ? $clog2(PN) : 1;

    logic [FW-1:0] bank_mem [NB][WL];

    logic [CW-1:0] pkt_cnt_q;
    logic [BW-1:0] wr_bank_q;
    logic [BW-1:0] rd_bank_q;
    logic [NB-1:0] full_q;
    logic [NB-1:0] full_d;
    logic          rd_busy_q;
    logic          wr_done_q;
    logic          vld_q;
    logic [FW-1:0] rdata_q;

    logic          wr_acc;
    logic          last_pkt;
    logic          rd_take;
    logic          rd_free;
    logic          addr_ok;
    logic [AW-1:0] waddr [PL];

    function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
        return (b == BW'(NB - 1)) ? '0 : b + BW'(1);
    endfunction

    assign wr_ready_o = ~full_q[wr_bank_q];
    assign wr_acc     = wr_valid_i & wr_ready_o;
    assign last_pkt   = (pkt_cnt_q == CW'(PN - 1));
    assign rd_take    = rd_req_i & ~rd_busy_q & full_q[rd_bank_q];
    assign rd_free    = rd_release_i & rd_busy_q;
    assign addr_ok    = ({1'b0, rd_addr_i} < (AW + 1)'(WL));

    // Modular AW-bit arithmetic is exact because every real address is < WL.
    for (genvar gi = 0; gi < PL; gi++) begin : g_waddr
        assign waddr[gi] = AW'(pkt_cnt_q) * AW'(PL) + AW'(gi);
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int j = 0; j < PL; j++) begin
                bank_mem[wr_bank_q][waddr[j]] <= param_i[j*FW +: FW];
            end
        end
    end

    // Release and completion never hit the same bank: the writer only fills a
    // non-full bank, the reader only releases a full one.
    always_comb begin
        full_d = full_q;
        if (rd_free) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_acc && last_pkt) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pkt_cnt_q <= '0;
            wr_bank_q <= '0;
            rd_bank_q <= '0;
            full_q    <= '0;
            rd_busy_q <= 1'b0;
            wr_done_q <= 1'b0;
            vld_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            full_q    <= full_d;
            wr_done_q <= wr_acc & last_pkt;
            if (wr_acc) begin
                if (last_pkt) begin
                    pkt_cnt_q <= '0;
                    wr_bank_q <= bank_inc(wr_bank_q);
                end else begin
                    pkt_cnt_q <= pkt_cnt_q + CW'(1);
                end
            end
            if (rd_take) begin
                rd_busy_q <= 1'b1;
            end else if (rd_free) begin
                rd_busy_q <= 1'b0;
                rd_bank_q <= bank_inc(rd_bank_q);
            end
            vld_q <= rd_busy_q;
            if (rd_busy_q) begin
                rdata_q <= addr_ok ? bank_mem[rd_bank_q][rd_addr_i] : '0;
            end
        end
    end

    assign wr_bank_o      = wr_bank_q;
    assign wr_done_o      = wr_done_q;
    assign full_o         = full_q;
    assign rd_busy_o      = rd_busy_q;
    assign rd_bank_o      = rd_bank_q;
    assign ip_param_o     = rdata_q;
    assign ip_param_vld_o = vld_q;

endmodule

// File: tb/tb_ip_param_nbuf.sv
// Bench for ip_param_nbuf: vector table, scenario sequences and a random run,
// all checked every cycle against a queue-free array model of the buffer.
`timescale 1ns/1ps
module tb_ip_param_nbuf;

    localparam int FW = 16;
    localparam int DW = 512;
    localparam int WL = 288;
    localparam int PL = 32;
    localparam int PN = 9;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // NB=2 instance
    logic          v = 0, req = 0, rel = 0;
    logic [DW-1:0] pkt = '0;
    logic [8:0]    addr = '0;
    logic          ready, done, busy, qv;
    logic [0:0]    wbank, rbank;
    logic [1:0]    full;
    logic [15:0]   q;

    // NB=3 instance
    logic          v3 = 0, req3 = 0, rel3 = 0;
    logic [DW-1:0] pkt3 = '0;
    logic [8:0]    addr3 = '0;
    logic          ready3, done3, busy3, qv3;
    logic [1:0]    wbank3, rbank3;
    logic [2:0]    full3;
    logic [15:0]   q3;

    ip_param_nbuf #(.FW(FW), .DW(DW), .WL(WL), .NB(2)) dut (
        .clk_i(clk), .rstn_i(rstn), .wr_valid_i(v), .param_i(pkt),
        .wr_ready_o(ready), .wr_bank_o(wbank), .wr_done_o(done), .full_o(full),
        .rd_req_i(req), .rd_busy_o(busy), .rd_bank_o(rbank), .rd_addr_i(addr),
        .rd_release_i(rel), .ip_param_o(q), .ip_param_vld_o(qv)
    );

    ip_param_nbuf #(.FW(FW), .DW(DW), .WL(WL), .NB(3)) dut3 (
        .clk_i(clk), .rstn_i(rstn), .wr_valid_i(v3), .param_i(pkt3),
        .wr_ready_o(ready3), .wr_bank_o(wbank3), .wr_done_o(done3), .full_o(full3),
        .rd_req_i(req3), .rd_busy_o(busy3), .rd_bank_o(rbank3), .rd_addr_i(addr3),
        .rd_release_i(rel3), .ip_param_o(q3), .ip_param_vld_o(qv3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int base);
        logic [DW-1:0] r;
        for (int j = 0; j < PL; j++) r[j*FW +: FW] = 16'(base + j);
        return r;
    endfunction

    // Behavioural model of the NB=2 instance
    int mmem [2][WL];
    int mcnt, mwb, mrb, mq;
    bit [1:0] mfull;
    bit mbusy, mdone, mvld;

    task automatic model_reset();
        mcnt = 0; mwb = 0; mrb = 0; mq = 0;
        mfull = '0; mbusy = 0; mdone = 0; mvld = 0;
    endtask

    task automatic model_step();
        bit [1:0] old_full = mfull;
        bit old_busy = mbusy;
        int old_rb = mrb;
        bit acc = v && !mfull[mwb];
        if (old_busy) begin
            mvld = 1;
            mq = (int'(addr) < WL) ? mmem[old_rb][int'(addr)] : 0;
        end else begin
            mvld = 0;
        end
        mdone = acc && (mcnt == PN - 1);
        if (acc) begin
            for (int j = 0; j < PL; j++) mmem[mwb][mcnt*PL + j] = int'(pkt[j*FW +: FW]);
            if (mcnt == PN - 1) begin
                mcnt = 0;
                mfull[mwb] = 1;
                mwb = (mwb + 1) % 2;
            end else begin
                mcnt++;
            end
        end
        if (!old_busy) begin
            if (req && old_full[old_rb]) mbusy = 1;
        end else if (rel) begin
            mfull[old_rb] = 0;
            mbusy = 0;
            mrb = (old_rb + 1) % 2;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("mdl_ready", ready, !mfull[mwb]);
        chk("mdl_wbank", wbank, mwb);
        chk("mdl_done",  done,  mdone);
        chk("mdl_full",  full,  mfull);
        chk("mdl_busy",  busy,  mbusy);
        chk("mdl_rbank", rbank, mrb);
        chk("mdl_vld",   qv,    mvld);
        chk("mdl_q",     q,     mq);
    endtask

    task automatic idle_inputs();
        v = 0; req = 0; rel = 0; addr = '0; pkt = '0;
        v3 = 0; req3 = 0; rel3 = 0; addr3 = '0; pkt3 = '0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic reset_mid();
        idle_inputs();
        @(posedge clk);
        #3 rstn = 0;
        #1;
        chk("rst_full",  full,  0);
        chk("rst_wbank", wbank, 0);
        chk("rst_rbank", rbank, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        chk("rst_vld",   qv,    0);
        chk("rst_q",     q,     0);
        chk("rst_ready", ready, 1);
        chk("rst3_full", full3, 0);
        chk("rst3_wbank", wbank3, 0);
        model_reset();
        @(posedge clk);
        #1 rstn = 1;
    endtask

    task automatic send(input int base);
        v = 1; pkt = mk(base);
        tick();
        v = 0;
    endtask

    typedef struct {
        bit v; int base; bit req; bit rel; int addr;
        bit e_ready; bit e_done; bit [1:0] e_full; bit e_busy; bit e_rbank;
        bit e_vld; int e_q; bit e_wbank;
    } vec_t;

    vec_t tbl [17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1);
    end

    initial begin
        int dn;
        // ---------------- vector table ----------------
        tbl[0]  = '{0, 0,   1, 0, 0,   1, 0, 2'b00, 0, 0, 0, 0,   0};
        tbl[1]  = '{0, 0,   0, 1, 0,   1, 0, 2'b00, 0, 0, 0, 0,   0};
        for (int k = 0; k < 8; k++)
            tbl[2+k] = '{1, k*32, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 256, 0, 0, 0,   1, 1, 2'b01, 0, 0, 0, 0,   1};
        tbl[11] = '{0, 0,   1, 1, 0,   1, 0, 2'b01, 1, 0, 0, 0,   1};
        tbl[12] = '{0, 0,   0, 0, 5,   1, 0, 2'b01, 1, 0, 1, 5,   1};
        tbl[13] = '{0, 0,   0, 0, 300, 1, 0, 2'b01, 1, 0, 1, 0,   1};
        tbl[14] = '{0, 0,   0, 0, 287, 1, 0, 2'b01, 1, 0, 1, 287, 1};
        tbl[15] = '{0, 0,   0, 1, 100, 1, 0, 2'b00, 0, 1, 1, 100, 1};
        tbl[16] = '{0, 0,   0, 0, 0,   1, 0, 2'b00, 0, 1, 0, 100, 1};

        reset_mid();
        for (int i = 0; i < 17; i++) begin
            v = tbl[i].v; pkt = mk(tbl[i].base); req = tbl[i].req;
            rel = tbl[i].rel; addr = 9'(tbl[i].addr);
            tick();
            chk($sformatf("vec%0d_ready", i), ready, tbl[i].e_ready);
            chk($sformatf("vec%0d_done",  i), done,  tbl[i].e_done);
            chk($sformatf("vec%0d_full",  i), full,  tbl[i].e_full);
            chk($sformatf("vec%0d_busy",  i), busy,  tbl[i].e_busy);
            chk($sformatf("vec%0d_rbank", i), rbank, tbl[i].e_rbank);
            chk($sformatf("vec%0d_vld",   i), qv,    tbl[i].e_vld);
            chk($sformatf("vec%0d_q",     i), q,     tbl[i].e_q);
            chk($sformatf("vec%0d_wbank", i), wbank, tbl[i].e_wbank);
        end
        idle_inputs();

        // ---------------- full bank read-out ----------------
        reset_mid();
        dn = 0;
        for (int k = 0; k < PN; k++) begin
            send(k * PL);
            dn += int'(done);
        end
        chk("fill_done_pulses", 64'(dn), 1);
        chk("fill_full", full, 2'b01);
        req = 1; tick(); req = 0;
        for (int a = 0; a < WL; a++) begin
            addr = 9'(a);
            tick();
            chk("readout_q", q, a);
            chk("readout_vld", qv, 1);
        end
        addr = 0;

        // ---------------- writer blocked on full banks ----------------
        reset_mid();
        for (int k = 0; k < 2*PN; k++) send(k * PL);
        chk("blk_full", full, 2'b11);
        chk("blk_ready", ready, 0);
        v = 1; pkt = mk(1000);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("blk_hold_ready", ready, 0);
            chk("blk_hold_wbank", wbank, 0);
        end
        req = 1; tick(); req = 0;
        rel = 1; tick(); rel = 0;
        chk("blk_release_ready", ready, 1);
        chk("blk_release_full", full, 2'b10);
        tick();
        v = 0;
        for (int k = 1; k < PN; k++) send(2000 + k * PL);
        chk("blk_refill_full", full, 2'b11);
        req = 1; tick(); req = 0;
        rel = 1; tick(); rel = 0;
        req = 1; tick(); req = 0;
        chk("blk_rbank", rbank, 0);
        for (int a = 0; a < PL; a++) begin
            addr = 9'(a);
            tick();
            chk("blk_landed_q", q, 1000 + a);
        end
        addr = 0;

        // ---------------- release + completion in one cycle ----------------
        reset_mid();
        for (int k = 0; k < PN; k++) send(k * PL);
        req = 1; tick(); req = 0;
        for (int k = 0; k < PN - 1; k++) send(5000 + k * PL);
        v = 1; pkt = mk(7000); rel = 1;
        tick();
        v = 0; rel = 0;
        chk("same_full", full, 2'b10);
        chk("same_rbank", rbank, 1);
        chk("same_wbank", wbank, 0);
        chk("same_done", done, 1);
        chk("same_busy", busy, 0);

        // ---------------- reset in the middle of a fill ----------------
        reset_mid();
        for (int k = 0; k < 4; k++) send(k * PL);
        reset_mid();
        for (int k = 0; k < PN; k++) begin
            send(300 + k * PL);
            chk("refill_done", done, (k == PN - 1));
        end
        chk("refill_full", full, 2'b01);
        chk("refill_wbank", wbank, 1);

        // ---------------- three-bank rotation ----------------
        reset_mid();
        v3 = 1;
        for (int k = 0; k < 3*PN; k++) begin
            pkt3 = mk(k * PL);
            if (k % PN == 0) chk("nb3_wbank", wbank3, k / PN);
            tick();
        end
        v3 = 0;
        chk("nb3_full", full3, 3'b111);
        chk("nb3_ready", ready3, 0);
        chk("nb3_wbank_wrap", wbank3, 0);
        for (int r = 0; r < 3; r++) begin
            chk("nb3_rbank", rbank3, r);
            req3 = 1; tick(); req3 = 0;
            chk("nb3_busy", busy3, 1);
            rel3 = 1; tick(); rel3 = 0;
        end
        chk("nb3_rbank_wrap", rbank3, 0);
        chk("nb3_full_empty", full3, 0);

        // ---------------- randomized run ----------------
        reset_mid();
        for (int c = 0; c < 3000; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            req = ($urandom_range(0, 3) == 0);
            rel = ($urandom_range(0, 5) == 0);
            addr = 9'($urandom_range(0, 511));
            for (int w = 0; w < DW / 32; w++) pkt[w*32 +: 32] = $urandom;
            tick();
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
